// File: rtl/piece_render_if.sv
// Render request/result bundle between the game controller (master)
// and the tetromino renderer (slave).
interface piece_render_if #(
  parameter int unsigned W  = 10,
  parameter int unsigned H  = 20,
  parameter int unsigned CW = 8
);
  logic              start;
  logic [2:0]        piece;
  logic [1:0]        rotate;
  logic [CW-1:0]     pos_x;       // two's complement
  logic [CW-1:0]     pos_y;       // two's complement
  logic [W*H-1:0]    board;
  logic              busy;
  logic              done;
  logic [W*H-1:0]    n_map;
  logic [W*H-1:0]    merged_map;
  logic              collision;
  logic [2:0]        cell_count;

  modport master (
    output start, piece, rotate, pos_x, pos_y, board,
    input  busy, done, n_map, merged_map, collision, cell_count
  );

  modport slave (
    input  start, piece, rotate, pos_x, pos_y, board,
    output busy, done, n_map, merged_map, collision, cell_count
  );
endinterface

// File: rtl/piece_render.sv
// Draws the active tetromino into a WxH bitmap one window cell per clock,
// flagging out-of-bounds and board-overlap collisions.
module piece_render #(
  parameter int unsigned W  = 10,
  parameter int unsigned H  = 20,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  piece_render_if.slave bus
);
  localparam int unsigned N  = W * H;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned KW = 5;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2:0]     piece_q, piece_d;
  logic [1:0]     rot_q, rot_d;
  logic [CW-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [N-1:0]   board_q, board_d;
  logic [N-1:0]   n_map_q, n_map_d;
  logic [N-1:0]   merged_q, merged_d;
  logic           coll_q, coll_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  function automatic logic [15:0] piece_mask(input logic [2:0] id);
    case (id)
      3'd1:    piece_mask = 16'h0720;
      3'd2:    piece_mask = 16'h0660;
      3'd3:    piece_mask = 16'h0360;
      3'd4:    piece_mask = 16'h0630;
      3'd5:    piece_mask = 16'h0470;
      3'd6:    piece_mask = 16'h0740;
      default: piece_mask = 16'h0F00;  // ids 0 and 7
    endcase
  endfunction

  // Mask bit for window cell (x,y) after r clockwise quarter turns.
  function automatic logic [3:0] mask_idx(input logic [1:0] r,
                                          input logic [1:0] x,
                                          input logic [1:0] y);
    case (r)
      2'd0:    mask_idx = {y, x};
      2'd1:    mask_idx = 4'd12 + {2'b00, y} - {x, 2'b00};
      2'd2:    mask_idx = 4'd15 - {y, 2'b00} - {2'b00, x};
      default: mask_idx = 4'd3 - {2'b00, y} + {x, 2'b00};
    endcase
  endfunction

  // Current-cell decode; one extra sign bit keeps negative coordinates from wrapping.
  logic [1:0]    cx, cy;
  logic [15:0]   mask;
  logic          cell_on;
  logic [SW-1:0] bx, by;
  logic          in_bounds;
  logic [AW-1:0] addr;

  assign cx        = k_q[1:0];
  assign cy        = k_q[3:2];
  assign mask      = piece_mask(piece_q);
  assign cell_on   = mask[mask_idx(rot_q, cx, cy)];
  assign bx        = {pos_x_q[CW-1], pos_x_q} + SW'(cx);
  assign by        = {pos_y_q[CW-1], pos_y_q} + SW'(cy);
  assign in_bounds = !bx[SW-1] && !by[SW-1] && (bx < SW'(W)) && (by < SW'(H));
  assign addr      = AW'(bx) * AW'(H) + AW'(by);

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    piece_d  = piece_q;
    rot_d    = rot_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    board_d  = board_q;
    n_map_d  = n_map_q;
    merged_d = merged_q;
    coll_d   = coll_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          piece_d = bus.piece;
          rot_d   = bus.rotate;
          pos_x_d = bus.pos_x;
          pos_y_d = bus.pos_y;
          board_d = bus.board;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        n_map_d = '0;
        coll_d  = 1'b0;
        cnt_d   = 3'd0;
        k_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        // k reaching 16 is a settle cycle so done lines up 18 clocks after start.
        if (k_q[KW-1]) begin
          merged_d = board_q | n_map_q;
          state_d  = DONE;
        end else begin
          if (cell_on) begin
            if (!in_bounds) begin
              coll_d = 1'b1;
            end else begin
              n_map_d[addr] = 1'b1;
              cnt_d         = cnt_q + 3'd1;
              if (board_q[addr]) coll_d = 1'b1;
            end
          end
          k_d = k_q + KW'(1);
        end
      end
    endcase

    busy_d = (state_d == CLEAR) || (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      piece_q  <= '0;
      rot_q    <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      board_q  <= '0;
      n_map_q  <= '0;
      merged_q <= '0;
      coll_q   <= 1'b0;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      piece_q  <= piece_d;
      rot_q    <= rot_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      board_q  <= board_d;
      n_map_q  <= n_map_d;
      merged_q <= merged_d;
      coll_q   <= coll_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.n_map      = n_map_q;
  assign bus.merged_map = merged_q;
  assign bus.collision  = coll_q;
  assign bus.cell_count = cnt_q;

endmodule

// File: tb/tb_piece_render.sv
// Scoreboard bench for piece_render: expectations queued at start, checked at done.
module tb_piece_render;
  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 8;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piece_render_if #(.W(W), .H(H), .CW(CW)) bus ();
  piece_render #(.W(W), .H(H), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [N-1:0] nm;
    logic [N-1:0] mg;
    logic         coll;
    logic [2:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference: walk the 4x4 window with the rotation index formulas.
  function automatic exp_t model(input int p, input int r, input int x, input int y,
                                 input logic [N-1:0] b);
    exp_t e;
    logic [15:0] m;
    int idx, bx, by;
    case (p)
      1: m = 16'h0720;  2: m = 16'h0660;  3: m = 16'h0360;
      4: m = 16'h0630;  5: m = 16'h0470;  6: m = 16'h0740;
      default: m = 16'h0F00;
    endcase
    e.nm = '0; e.coll = 1'b0; e.cnt = 3'd0;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 4; px++) begin
        case (r)
          0: idx = 4*py + px;
          1: idx = 12 + py - 4*px;
          2: idx = 15 - 4*py - px;
          default: idx = 3 - py + 4*px;
        endcase
        if (m[idx]) begin
          bx = x + px;
          by = y + py;
          if (bx < 0 || bx >= W || by < 0 || by >= H) e.coll = 1'b1;
          else begin
            e.nm[H*bx + by] = 1'b1;
            e.cnt = e.cnt + 3'd1;
            if (b[H*bx + by]) e.coll = 1'b1;
          end
        end
      end
    end
    e.mg = b | e.nm;
    return e;
  endfunction

  function automatic logic [N-1:0] bits4(input int a, input int b, input int c, input int d);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(3) == 0);
    return v;
  endfunction

  task automatic apply(input int p, input int r, input int x, input int y, input logic [N-1:0] b);
    bus.piece  = 3'(p);
    bus.rotate = 2'(r);
    bus.pos_x  = CW'(x);
    bus.pos_y  = CW'(y);
    bus.board  = b;
    bus.start  = 1'b1;
  endtask

  // Inputs wander after acceptance; the running render must not notice.
  task automatic scramble();
    bus.start  = 1'b0;
    bus.piece  = 3'($urandom);
    bus.rotate = 2'($urandom);
    bus.pos_x  = CW'($urandom);
    bus.pos_y  = CW'($urandom);
    bus.board  = rand_board();
  endtask

  // Queue the expectation, present the request, and release it after edge E0.
  task automatic launch(input int p, input int r, input int x, input int y,
                        input logic [N-1:0] b, input exp_t e);
    sb.push_back(e);
    apply(p, r, x, y, b);
    @(posedge clk); #1;
    scramble();
  endtask

  // Cycles since E0 at which done is seen; -1 if it never arrives.
  task automatic wait_done(input int from, output int lat);
    lat = -1;
    for (int i = from + 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.collision, bus.cell_count} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.done, bus.collision, bus.cell_count});
    end
    vectors++;
    if ((bus.n_map | bus.merged_map) !== '0) begin
      miscompares++;
      $display("FAIL reset_maps: got n_map=%h merged=%h want 0", bus.n_map, bus.merged_map);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plan();
    int xs[5] = '{3, 0, 8, -1, 3};
    int rs[5] = '{0, 1, 0, 0, 0};
    int bl[5][4] = '{'{62, 82, 102, 122}, '{20, 21, 22, 23}, '{162, 182, -1, -1},
                     '{2, 22, 42, -1}, '{62, 82, 102, 122}};
    int cn[5] = '{4, 4, 2, 3, 4};
    int cl[5] = '{0, 0, 1, 1, 1};
    for (int t = 0; t < 5; t++) begin
      exp_t e, g;
      logic [N-1:0] b;
      int lat;
      b = (t == 4) ? bits4(62, -1, -1, -1) : '0;
      e.nm   = bits4(bl[t][0], bl[t][1], bl[t][2], bl[t][3]);
      e.mg   = e.nm | b;
      e.coll = cl[t][0];
      e.cnt  = 3'(cn[t]);
      launch(0, rs[t], xs[t], 0, b, e);
      wait_done(0, lat);
      g = sb.pop_front();
      vectors++;
      if (lat !== 18) begin miscompares++; $display("FAIL plan%0d_latency: got %0d want 18", t, lat); end
      vectors++;
      if (bus.n_map !== g.nm) begin miscompares++; $display("FAIL plan%0d_n_map: got %h want %h", t, bus.n_map, g.nm); end
      vectors++;
      if (bus.merged_map !== g.mg) begin miscompares++; $display("FAIL plan%0d_merged: got %h want %h", t, bus.merged_map, g.mg); end
      vectors++;
      if ({bus.collision, bus.cell_count} !== {g.coll, g.cnt}) begin
        miscompares++;
        $display("FAIL plan%0d_coll_cnt: got %b/%0d want %b/%0d", t, bus.collision, bus.cell_count, g.coll, g.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      exp_t g;
      logic [N-1:0] b;
      int p, r, x, y, lat;
      p = int'($urandom_range(7));
      r = int'($urandom_range(3));
      x = int'($urandom_range(14)) - 3;
      y = int'($urandom_range(24)) - 3;
      b = rand_board();
      launch(p, r, x, y, b, model(p, r, x, y, b));
      wait_done(0, lat);
      g = sb.pop_front();
      vectors++;
      if (lat !== 18) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want 18", t, lat); end
      vectors++;
      if ({bus.n_map, bus.merged_map} !== {g.nm, g.mg}) begin
        miscompares++;
        $display("FAIL rand%0d_maps p=%0d r=%0d x=%0d y=%0d: got n_map=%h want %h", t, p, r, x, y, bus.n_map, g.nm);
      end
      vectors++;
      if ({bus.collision, bus.cell_count} !== {g.coll, g.cnt}) begin
        miscompares++;
        $display("FAIL rand%0d_coll_cnt: got %b/%0d want %b/%0d", t, bus.collision, bus.cell_count, g.coll, g.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    exp_t g;
    int lat, extra;
    launch(2, 1, 4, 7, '0, model(2, 1, 4, 7, '0));
    repeat (4) @(posedge clk);
    #1;
    apply(0, 0, 3, 0, '0);
    @(posedge clk); #1;
    scramble();
    wait_done(5, lat);
    g = sb.pop_front();
    vectors++;
    if (lat !== 18) begin miscompares++; $display("FAIL ignore_latency: got %0d want 18", lat); end
    vectors++;
    if ({bus.n_map, bus.collision, bus.cell_count} !== {g.nm, g.coll, g.cnt}) begin
      miscompares++;
      $display("FAIL ignore_result: got n_map=%h cnt=%0d want %h cnt=%0d", bus.n_map, bus.cell_count, g.nm, g.cnt);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("FAIL ignore_no_second: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    exp_t g;
    int la, lb;
    logic [N-1:0] b;
    b = rand_board();
    launch(5, 2, 2, 5, '0, model(5, 2, 2, 5, '0));
    wait_done(0, la);
    g = sb.pop_front();
    vectors++;
    if (la !== 18) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 18", la); end
    vectors++;
    if ({bus.merged_map, bus.collision, bus.cell_count} !== {g.mg, g.coll, g.cnt}) begin
      miscompares++;
      $display("FAIL b2b_first_result: got merged=%h want %h", bus.merged_map, g.mg);
    end
    launch(6, 3, 7, 17, b, model(6, 3, 7, 17, b));
    wait_done(0, lb);
    g = sb.pop_front();
    vectors++;
    if (lb + 1 !== 19) begin miscompares++; $display("FAIL b2b_period: got %0d want 19", lb + 1); end
    vectors++;
    if ({bus.merged_map, bus.n_map, bus.collision, bus.cell_count} !== {g.mg, g.nm, g.coll, g.cnt}) begin
      miscompares++;
      $display("FAIL b2b_second_result: got n_map=%h coll=%b want %h coll=%b", bus.n_map, bus.collision, g.nm, g.coll);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t g;
    int seen, lat;
    launch(1, 0, 4, 3, '0, model(1, 0, 4, 3, '0));
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    void'(sb.pop_front());
    vectors++;
    if ({bus.busy, bus.done, bus.collision, bus.cell_count} !== 6'd0) begin
      miscompares++;
      $display("FAIL midrst_flags: got %b want 000000", {bus.busy, bus.done, bus.collision, bus.cell_count});
    end
    vectors++;
    if ((bus.n_map | bus.merged_map) !== '0) begin
      miscompares++;
      $display("FAIL midrst_maps: got n_map=%h merged=%h want 0", bus.n_map, bus.merged_map);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen); end
    launch(3, 1, 0, 0, bits4(1, -1, -1, -1), model(3, 1, 0, 0, bits4(1, -1, -1, -1)));
    wait_done(0, lat);
    g = sb.pop_front();
    vectors++;
    if (lat !== 18) begin miscompares++; $display("FAIL midrst_restart_latency: got %0d want 18", lat); end
    vectors++;
    if ({bus.merged_map, bus.collision, bus.cell_count} !== {g.mg, g.coll, g.cnt}) begin
      miscompares++;
      $display("FAIL midrst_restart_result: got merged=%h coll=%b cnt=%0d want %h coll=%b cnt=%0d",
               bus.merged_map, bus.collision, bus.cell_count, g.mg, g.coll, g.cnt);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.piece  = 3'd0;
    bus.rotate = 2'd0;
    bus.pos_x  = '0;
    bus.pos_y  = '0;
    bus.board  = '0;
    test_reset();
    test_plan();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
